// File: rtl/snake_core.sv
// Snake game engine: ring-buffer body, step timer, growth, self/wall collision
// and game-over/restart, exporting an occupancy bitmap for the LED matrix scanner.
module snake_core #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 1,
  parameter int STEP_DIV = 1200000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic [$clog2(COLS)-1:0]      food_x,
  input  logic [$clog2(ROWS)-1:0]      food_y,
  input  logic                         food_valid,
  output logic [ROWS*COLS-1:0]         frame,
  output logic [$clog2(COLS)-1:0]      head_x,
  output logic [$clog2(ROWS)-1:0]      head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         step,
  output logic                         eat,
  output logic                         dead,
  output logic                         running
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int LW = $clog2(MAX_LEN+1);
  localparam int PW = $clog2(MAX_LEN);
  localparam int FW = $clog2(ROWS*COLS);
  localparam int CW = $clog2(STEP_DIV+1);
  localparam int NB = ROWS*COLS;

  localparam logic [XW-1:0] LAST_X = XW'(COLS-1);
  localparam logic [YW-1:0] LAST_Y = YW'(ROWS-1);
  localparam logic [XW-1:0] INIT_X = XW'(INIT_LEN-1);
  localparam logic [YW-1:0] MID_Y  = YW'(ROWS/2);
  localparam logic [FW-1:0] COLS_F = FW'(COLS);
  localparam logic [NB-1:0] ONE_NB = NB'(1);
  localparam logic [NB-1:0] INIT_FRAME = ((ONE_NB << INIT_LEN) - ONE_NB) << ((ROWS/2)*COLS);

  // XOR with 1 maps each direction to its opposite
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
  state_t state, state_nx;

  logic [3:0]    btn_now, btn_prev, edges;
  logic          any_edge, restart, req_ok, tick;
  logic [1:0]    dir, pend, req_dir, base_dir;
  logic [CW-1:0] cnt;
  logic [PW-1:0] hp, tp;
  logic [XW-1:0] body_x [MAX_LEN];
  logic [YW-1:0] body_y [MAX_LEN];
  logic [XW-1:0] nx, tail_x;
  logic [YW-1:0] ny, tail_y;
  logic          off_grid, grow, keep_tail, collide, fatal, move;
  logic [FW-1:0] head_idx, tail_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN-1)) ? '0 : p + PW'(1);
  endfunction

  assign btn_now  = {btn_up, btn_down, btn_left, btn_right};
  assign edges    = btn_now & ~btn_prev;
  assign any_edge = |edges;
  assign restart  = (state != S_RUN) && any_edge;
  assign tick     = (state == S_RUN) && (cnt == CW'(STEP_DIV-1));
  assign base_dir = (state != S_RUN) ? D_RIGHT : (tick ? pend : dir);

  always_comb begin
    req_dir = D_RIGHT;
    if (edges[3])      req_dir = D_UP;
    else if (edges[2]) req_dir = D_DOWN;
    else if (edges[1]) req_dir = D_LEFT;
    req_ok = any_edge && (req_dir != (base_dir ^ 2'b01));
  end

  always_comb begin
    nx = head_x;
    ny = head_y;
    off_grid = 1'b0;
    case (pend)
      D_UP:    if (head_y == '0)   begin ny = LAST_Y; off_grid = 1'b1; end else ny = head_y - YW'(1);
      D_DOWN:  if (head_y == LAST_Y) begin ny = '0;   off_grid = 1'b1; end else ny = head_y + YW'(1);
      D_LEFT:  if (head_x == '0)   begin nx = LAST_X; off_grid = 1'b1; end else nx = head_x - XW'(1);
      default: if (head_x == LAST_X) begin nx = '0;   off_grid = 1'b1; end else nx = head_x + XW'(1);
    endcase
  end

  assign tail_x    = body_x[tp];
  assign tail_y    = body_y[tp];
  assign head_idx  = FW'(ny) * COLS_F + FW'(nx);
  assign tail_idx  = FW'(tail_y) * COLS_F + FW'(tail_x);
  assign grow      = food_valid && (nx == food_x) && (ny == food_y);
  assign keep_tail = grow && (length < LW'(MAX_LEN));
  // Moving onto the tail cell is legal when the tail leaves in the same step
  assign collide   = frame[head_idx] && !((nx == tail_x) && (ny == tail_y) && !keep_tail);
  assign fatal     = (off_grid && (WRAP == 0)) || collide;
  assign move      = tick && !fatal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DEAD: if (any_edge) state_nx = S_RUN;
      S_RUN:          if (tick && fatal) state_nx = S_DEAD;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state == S_RUN);
    dead    = (state == S_DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
      cnt      <= '0;
      step     <= 1'b0;
      eat      <= 1'b0;
      dir      <= D_RIGHT;
      pend     <= D_RIGHT;
      frame    <= INIT_FRAME;
      head_x   <= INIT_X;
      head_y   <= MID_Y;
      length   <= LW'(INIT_LEN);
      hp       <= PW'(INIT_LEN-1);
      tp       <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= (i < INIT_LEN) ? XW'(i) : '0;
        body_y[i] <= MID_Y;
      end
    end else begin
      btn_prev <= btn_now;
      step     <= move;
      eat      <= move && grow;
      if (restart) begin
        cnt    <= '0;
        dir    <= D_RIGHT;
        pend   <= req_ok ? req_dir : D_RIGHT;
        frame  <= INIT_FRAME;
        head_x <= INIT_X;
        head_y <= MID_Y;
        length <= LW'(INIT_LEN);
        hp     <= PW'(INIT_LEN-1);
        tp     <= '0;
        for (int i = 0; i < MAX_LEN; i++) begin
          body_x[i] <= (i < INIT_LEN) ? XW'(i) : '0;
          body_y[i] <= MID_Y;
        end
      end else if (state == S_RUN) begin
        cnt <= tick ? '0 : cnt + CW'(1);
        if (tick)   dir  <= pend;
        if (req_ok) pend <= req_dir;
        if (move) begin
          hp                 <= ptr_inc(hp);
          body_x[ptr_inc(hp)] <= nx;
          body_y[ptr_inc(hp)] <= ny;
          head_x             <= nx;
          head_y             <= ny;
          if (keep_tail) begin
            length <= length + LW'(1);
          end else begin
            frame[tail_idx] <= 1'b0;
            tp              <= ptr_inc(tp);
          end
          // Set after the clear so a head entering the vacated tail cell wins
          frame[head_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_core.sv
// Bench for snake_core: directed moves on an 8x8 grid, with a scoreboard of
// expected per-step results checked by an independent monitor.
`timescale 1ns/1ps
module tb_snake_core;
  localparam int ROWS = 8, COLS = 8, MAX_LEN = 8, INIT_LEN = 3, STEP_DIV = 4;
  localparam logic [63:0] F_INIT = 64'h0000_0007_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [2:0] food_x = '0, food_y = '0;
  logic food_valid = 1'b0;

  logic [63:0] frame_a, frame_b;
  logic [2:0]  head_x_a, head_y_a, head_x_b, head_y_b;
  logic [3:0]  length_a, length_b;
  logic        step_a, eat_a, dead_a, running_a;
  logic        step_b, eat_b, dead_b, running_b;

  snake_core #(.ROWS(ROWS), .COLS(COLS), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
               .WRAP(1), .STEP_DIV(STEP_DIV)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .frame(frame_a), .head_x(head_x_a), .head_y(head_y_a),
    .length(length_a), .step(step_a), .eat(eat_a), .dead(dead_a), .running(running_a));

  snake_core #(.ROWS(ROWS), .COLS(COLS), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
               .WRAP(0), .STEP_DIV(STEP_DIV)) dut_wall (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .frame(frame_b), .head_x(head_x_b), .head_y(head_y_b),
    .length(length_b), .step(step_b), .eat(eat_b), .dead(dead_b), .running(running_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  hx;
    logic [2:0]  hy;
    logic [3:0]  len;
    logic        eat;
    logic [63:0] frm;
  } exp_t;

  exp_t sbq[$];
  int tests = 0, fails = 0;
  int cyc = 0, na = 0, nb = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && step_a) na <= na + 1;
  always @(negedge clk) if (rst_n && step_b) nb <= nb + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Monitor: every step pulse of the wrap instance consumes one expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && step_a) begin
      if (sbq.size() == 0) begin
        fail_now("unexpected_step", $sformatf("head=(%0d,%0d), required no step", head_x_a, head_y_a));
      end else begin
        e = sbq.pop_front();
        chk("step_head_x", 64'(head_x_a), 64'(e.hx));
        chk("step_head_y", 64'(head_y_a), 64'(e.hy));
        chk("step_length", 64'(length_a), 64'(e.len));
        chk("step_eat",    64'(eat_a),    64'(e.eat));
        chk("step_frame",  frame_a,       e.frm);
      end
    end
  end

  task automatic expect_step(input int hx, input int hy, input int len, input bit e, input logic [63:0] frm);
    exp_t x;
    x.hx = 3'(hx); x.hy = 3'(hy); x.len = 4'(len); x.eat = e; x.frm = frm;
    sbq.push_back(x);
  endtask

  // 0 right, 1 left, 2 down, 3 up; called at a negedge, holds one cycle
  task automatic press(input int which);
    case (which)
      3:       btn_up    = 1'b1;
      2:       btn_down  = 1'b1;
      1:       btn_left  = 1'b1;
      default: btn_right = 1'b1;
    endcase
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic wait_step(input string name, output int at);
    int n = 0;
    at = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!step_a && n < 20);
    if (!step_a) fail_now(name, "no step pulse within 20 cycles");
    else at = cyc;
  endtask

  task automatic set_food(input int x, input int y);
    food_x = 3'(x); food_y = 3'(y); food_valid = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t1, t2, t3, tx, n;
    #12;
    chk("reset_frame",   frame_a,            F_INIT);
    chk("reset_head_x",  64'(head_x_a),      64'd2);
    chk("reset_head_y",  64'(head_y_a),      64'd4);
    chk("reset_length",  64'(length_a),      64'd3);
    chk("reset_running", 64'(running_a),     64'd0);
    chk("reset_dead",    64'(dead_a),        64'd0);
    chk("reset_step",    64'(step_a),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_no_steps", 64'(na),        64'd0);
    chk("idle_running",  64'(running_a), 64'd0);

    press(0);
    chk("start_running", 64'(running_a), 64'd1);
    chk("start_frame",   frame_a,        F_INIT);

    expect_step(3, 4, 3, 0, 64'h0000_000E_0000_0000);
    wait_step("s1", t1);
    press(1);  // reversal, must be ignored
    expect_step(4, 4, 3, 0, 64'h0000_001C_0000_0000);
    wait_step("s2", t2);
    chk("step_interval_1", 64'(t2 - t1), 64'd4);
    set_food(5, 4);
    expect_step(5, 4, 4, 1, 64'h0000_003C_0000_0000);
    wait_step("s3", t3);
    chk("step_interval_2", 64'(t3 - t2), 64'd4);
    set_food(6, 4);
    expect_step(6, 4, 5, 1, 64'h0000_007C_0000_0000);
    wait_step("s4", tx);
    set_food(7, 4);
    expect_step(7, 4, 6, 1, 64'h0000_00FC_0000_0000);
    wait_step("s5", tx);
    set_food(0, 4);
    expect_step(0, 4, 7, 1, 64'h0000_00FD_0000_0000);
    wait_step("s6_wrap", tx);
    chk("wall_dead",    64'(dead_b),    64'd1);
    chk("wall_running", 64'(running_b), 64'd0);
    chk("wall_frame",   frame_b,        64'h0000_00FC_0000_0000);
    chk("wall_head_x",  64'(head_x_b),  64'd7);
    chk("wall_length",  64'(length_b),  64'd6);
    chk("wall_steps",   64'(nb),        64'd5);

    set_food(1, 4);
    expect_step(1, 4, 8, 1, 64'h0000_00FF_0000_0000);
    wait_step("s7", tx);
    set_food(2, 4);  // food on the tail cell at full length
    expect_step(2, 4, 8, 1, 64'h0000_00FF_0000_0000);
    wait_step("s8_sat", tx);
    food_valid = 1'b0;
    expect_step(3, 4, 8, 0, 64'h0000_00FF_0000_0000);
    wait_step("s9_tail", tx);

    press(3);
    expect_step(3, 3, 8, 0, 64'h0000_00EF_0800_0000);
    wait_step("s10_up", tx);
    press(3);
    press(1);
    expect_step(2, 3, 8, 0, 64'h0000_00CF_0C00_0000);
    wait_step("s11_left", tx);
    press(2);
    n = 0;
    while (!dead_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dead_a) fail_now("self_collision", "dead never rose");
    chk("dead_running", 64'(running_a), 64'd0);
    chk("dead_frame",   frame_a,        64'h0000_00CF_0C00_0000);
    chk("dead_head_x",  64'(head_x_a),  64'd2);
    chk("dead_head_y",  64'(head_y_a),  64'd3);
    chk("dead_length",  64'(length_a),  64'd8);
    chk("dead_steps",   64'(na),        64'd11);

    press(0);
    chk("restart_running", 64'(running_a), 64'd1);
    chk("restart_dead",    64'(dead_a),    64'd0);
    chk("restart_frame",   frame_a,        F_INIT);
    chk("restart_length",  64'(length_a),  64'd3);
    chk("restart_head_x",  64'(head_x_a),  64'd2);
    expect_step(3, 4, 3, 0, 64'h0000_000E_0000_0000);
    wait_step("s12_after_restart", tx);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_frame",   frame_a,        F_INIT);
    chk("midrun_reset_head_x",  64'(head_x_a),  64'd2);
    chk("midrun_reset_length",  64'(length_a),  64'd3);
    chk("midrun_reset_running", 64'(running_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_steps",  64'(na),         64'd12);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snake_core.md
Name: snake_core

Overview:
- Parametrised snake game engine for the LED-matrix snake design. Generalises the fixed 8x8 game to any grid size, maximum body length and edge mode (wrap or wall).
- Takes debounced direction buttons and a food position from upstream. Exports an occupancy framebuffer for the matrix scanner, plus status pulses.
- Owns body storage (circular coordinate buffer), step timing, growth, collision and game-over/restart.

Parameters:
- ROWS, 8, grid height.
- COLS, 8, grid width.
- MAX_LEN, 16, body-buffer depth and maximum length (>= INIT_LEN+1).
- INIT_LEN, 3, length after reset/restart (<= COLS).
- WRAP, 1, edge mode: 1 = wrap around, 0 = wall kills.
- STEP_DIV, 1200000, clk cycles per game step (100 ms at 12 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_up  in  1  debounced level
- btn_down  in  1  debounced level
- btn_left  in  1  debounced level
- btn_right  in  1  debounced level
- food_x  in  $clog2(COLS)  food column
- food_y  in  $clog2(ROWS)  food row
- food_valid  in  1  food present
- frame  out  ROWS*COLS  occupancy bitmap, bit index y*COLS+x
- head_x  out  $clog2(COLS)  head column
- head_y  out  $clog2(ROWS)  head row
- length  out  $clog2(MAX_LEN+1)  current body length
- step  out  1  one-cycle pulse per committed move
- eat  out  1  one-cycle pulse, coincident with step, when food was eaten
- dead  out  1  level, high in DEAD
- running  out  1  level, high in RUN

Behaviour:
- Reset (async assert, sync release). Applies mid-game too; no partial state survives.
  - Body = cells (0..INIT_LEN-1, ROWS/2); head at (INIT_LEN-1, ROWS/2).
  - Direction = right; length = INIT_LEN; frame holds exactly those bits.
  - step = eat = dead = running = 0; state IDLE; tick counter 0.
- Buttons: rising edges are detected internally.
  - Simultaneous edges: priority up > down > left > right.
  - A request opposite to the current committed direction is ignored.
  - An accepted request is stored as the pending direction. The last accepted request before a step wins and commits at that step.
- FSM:
  - IDLE: any button edge -> RUN; tick counter cleared; that press is applied as a direction request (left is ignored, it reverses right).
  - RUN: tick counter counts 0..STEP_DIV-1. On terminal count, next head = head + committed direction.
  - DEAD: frame, head and length are frozen. Any button edge re-initialises to the reset configuration and enters RUN.
- Edge handling:
  - WRAP=1: coordinates wrap modulo COLS/ROWS.
  - WRAP=0: leaving the grid -> DEAD; no move is committed and step does not pulse.
- Growth: grow = food_valid and next head == (food_x, food_y), sampled on the tick cycle.
  - If grow and length < MAX_LEN: tail is kept and length increments.
  - If grow at MAX_LEN: eat still pulses, length saturates, tail is removed.
- Collision: next head lands on an occupied frame bit -> DEAD.
  - Exception: that bit is the current tail cell and the tail is vacating (not growing).
- Move commit (registered on the tick cycle, visible the next cycle):
  - Set the head bit; clear the tail bit unless growing.
  - Update head_x/head_y; pulse step (and eat if grow).
  - Latency from terminal count to updated outputs: 1 cycle.
- Death: dead rises 1 cycle after the fatal tick; running falls at the same edge. No step pulse for the fatal tick.
- Food: not validated by the core (the placer avoids the body). food_valid low = no food.

Test Plan (ROWS=COLS=8, MAX_LEN=8, INIT_LEN=3, STEP_DIV=4):
1. Reset -> frame=64'h0000_0007_0000_0000, head=(2,4), length=3, running=0. 40 idle cycles -> no step pulses. Assert rst_n low mid-RUN -> same values immediately.
2. btn_right edge -> running=1. step exactly every 4 cycles; after the first step head=(3,4), frame=64'h0000_000E_0000_0000.
3. While moving right, pulse btn_left -> ignored, head_x keeps incrementing. btn_up then btn_left within one step window -> left wins, head moves x-1.
4. WRAP=1: head (7,4) next step -> (0,4), frame bit 32 set. WRAP=0 instance: same step -> dead=1, no step pulse, frame unchanged.
5. food (5,4) valid, moving right from head (4,4) -> eat and step pulse together, length 3->4, tail bit retained. Repeat until length=8 -> eat pulses, length stays 8.
6. length 5 heading right: up, left, down on consecutive steps -> dead=1 on the down step. Then btn_right -> reset frame restored, running=1, length=3.
